// File: rtl/decode_stage.sv
// Decode stage: field split, register file, load-use stall, JMP redirect with one-slot squash.
// Optional macro DECODE_BYPASS_EN: same-cycle writeback data forwarded onto register reads.
module decode_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 5,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] insReg,
    input  logic            in_valid,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            jump,
    output logic [PC_W-1:0] jumpPC,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3
);

    localparam int unsigned RW = 5;
    localparam logic [6:0] OP_ALUR  = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JMP   = 7'b1101111;

    logic [6:0]    opcode;
    logic [RW-1:0] rd, rs1, rs2;
    logic [2:0]    funct3;
    logic          is_alur, is_alui, is_load, is_store, is_jmp;
    logic          use_rs1, use_rs2, hazard, issue;
    logic          squash_q;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] regs [NREG];

    assign opcode = insReg[6:0];
    assign rd     = insReg[11:7];
    assign funct3 = insReg[14:12];
    assign rs1    = insReg[19:15];
    assign rs2    = insReg[24:20];

    assign is_alur  = (opcode == OP_ALUR);
    assign is_alui  = (opcode == OP_ALUI);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_jmp   = (opcode == OP_JMP);
    assign use_rs1  = is_alur | is_alui | is_load | is_store;
    assign use_rs2  = is_alur | is_store;

    // Immediate selection by format
    always_comb begin
        imm = '0;
        if (is_alui || is_load)
            imm = {{(XLEN-12){insReg[31]}}, insReg[31:20]};
        else if (is_store)
            imm = {{(XLEN-12){insReg[31]}}, insReg[31:25], insReg[11:7]};
    end

    // Register reads; x0 hardwired to zero
    always_comb begin
        rs1_data = (rs1 == '0) ? '0 : regs[rs1];
        rs2_data = (rs2 == '0) ? '0 : regs[rs2];
`ifdef DECODE_BYPASS_EN
        if (wb_en && wb_addr != '0 && wb_addr == rs1) rs1_data = wb_data;
        if (wb_en && wb_addr != '0 && wb_addr == rs2) rs2_data = wb_data;
`endif
    end

    // Load in EX whose destination feeds this instruction
    assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));

    assign stall  = rst_n && in_valid && !squash_q && hazard;
    assign jump   = rst_n && in_valid && !squash_q && !stall && is_jmp;
    assign jumpPC = PC_W'(rs1);
    assign issue  = in_valid && !squash_q && !stall && !is_jmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) squash_q <= 1'b0;
        else        squash_q <= jump;
    end

    // EX pipeline register; anything not issued becomes an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
        end else if (issue) begin
            ex_valid     <= 1'b1;
            ex_reg_write <= is_alur | is_alui | is_load;
            ex_mem_read  <= is_load;
            ex_mem_write <= is_store;
            ex_alu_src   <= is_alui | is_load | is_store;
            ex_rs1_data  <= rs1_data;
            ex_rs2_data  <= rs2_data;
            ex_imm       <= imm;
            ex_rd        <= rd;
            ex_funct3    <= funct3;
        end else begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, field decode, x0, JMP/squash, load-use, bypass, reset mid-stall.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] insReg;
    logic        in_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall, jump;
    logic [4:0]  jumpPC;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;

    int total = 0;
    int bad   = 0;

    decode_stage #(.XLEN(32), .PC_W(5), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .insReg(insReg), .in_valid(in_valid),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .jump(jump), .jumpPC(jumpPC),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3)
    );

    always #5 clk = ~clk;

    // Instruction encodings used below
    localparam logic [31:0] ADDI_6_5_M1 = {12'hFFF, 5'd5, 3'd0, 5'd6, 7'b0010011};
    localparam logic [31:0] ADDI_6_0_5  = {12'h005, 5'd0, 3'd0, 5'd6, 7'b0010011};
    localparam logic [31:0] JMP_13      = {12'h000, 5'h13, 3'd0, 5'd0, 7'b1101111};
    localparam logic [31:0] LW_7        = {12'h000, 5'd2, 3'd2, 5'd7, 7'b0000011};
    localparam logic [31:0] ADD_8_7_1   = {7'd0, 5'd1, 5'd7, 3'd0, 5'd8, 7'b0110011};
    localparam logic [31:0] SW_5_M4     = {7'h7F, 5'd5, 5'd2, 3'd2, 5'h1C, 7'b0100011};
    localparam logic [31:0] ADDI_10_9_0 = {12'h000, 5'd9, 3'd0, 5'd10, 7'b0010011};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bypass_exp;
`ifdef DECODE_BYPASS_EN
        bypass_exp = 32'h0000_1234;
`else
        bypass_exp = 32'h0000_1111;
`endif
        rst_n = 1'b0; insReg = '0; in_valid = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_jump", 32'(jump), 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_reg_write", 32'(ex_reg_write), 32'd0);
        step();
        rst_n = 1'b1;

        // Write x5 then addi x6,x5,-1
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_00AA;
        step();
        wb_en = 1'b0; insReg = ADDI_6_5_M1; in_valid = 1'b1;
        step();
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_rs1", ex_rs1_data, 32'h0000_00AA);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(ex_rd), 32'd6);
        chk("addi_reg_write", 32'(ex_reg_write), 32'd1);
        chk("addi_alu_src", 32'(ex_alu_src), 32'd1);
        chk("addi_mem_read", 32'(ex_mem_read), 32'd0);

        // Write to x0 is discarded
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        wb_en = 1'b0; insReg = ADDI_6_0_5; in_valid = 1'b1;
        step();
        chk("x0_rs1", ex_rs1_data, 32'd0);
        chk("x0_imm", ex_imm, 32'd5);

        // JMP redirect, squash of next slot (even another JMP), then normal issue
        insReg = JMP_13;
        #1;
        chk("jmp_jump", 32'(jump), 32'd1);
        chk("jmp_pc", 32'(jumpPC), 32'h13);
        chk("jmp_stall", 32'(stall), 32'd0);
        step();
        chk("jmp_ex_valid", 32'(ex_valid), 32'd0);
        #1;
        chk("squash_jump", 32'(jump), 32'd0);
        step();
        chk("squash_ex_valid", 32'(ex_valid), 32'd0);
        insReg = ADDI_6_5_M1;
        #1;
        chk("post_squash_jump", 32'(jump), 32'd0);
        step();
        chk("post_squash_valid", 32'(ex_valid), 32'd1);
        chk("post_squash_rd", 32'(ex_rd), 32'd6);

        // Load-use stall
        insReg = LW_7;
        step();
        chk("lw_valid", 32'(ex_valid), 32'd1);
        chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
        chk("lw_rd", 32'(ex_rd), 32'd7);
        chk("lw_imm", ex_imm, 32'd0);
        insReg = ADD_8_7_1;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        step();
        chk("bubble_valid", 32'(ex_valid), 32'd0);
        chk("bubble_reg_write", 32'(ex_reg_write), 32'd0);
        chk("bubble_mem_read", 32'(ex_mem_read), 32'd0);
        chk("post_bubble_stall", 32'(stall), 32'd0);
        step();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rd", 32'(ex_rd), 32'd8);
        chk("add_reg_write", 32'(ex_reg_write), 32'd1);
        chk("add_alu_src", 32'(ex_alu_src), 32'd0);
        chk("add_imm", ex_imm, 32'd0);

        // Store immediate and rs2 data
        insReg = SW_5_M4;
        step();
        chk("sw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("sw_mem_write", 32'(ex_mem_write), 32'd1);
        chk("sw_reg_write", 32'(ex_reg_write), 32'd0);
        chk("sw_rs2", ex_rs2_data, 32'h0000_00AA);

        // in_valid low: no jump, bubble
        insReg = JMP_13; in_valid = 1'b0;
        #1;
        chk("inv_jump", 32'(jump), 32'd0);
        step();
        chk("inv_ex_valid", 32'(ex_valid), 32'd0);

        // Same-cycle writeback vs read
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_1111;
        step();
        wb_data = 32'h0000_1234; insReg = ADDI_10_9_0; in_valid = 1'b1;
        step();
        chk("same_cycle_rd", ex_rs1_data, bypass_exp);
        wb_en = 1'b0;
        step();
        chk("next_cycle_rd", ex_rs1_data, 32'h0000_1234);

        // Reset asserted while stalled
        insReg = LW_7;
        step();
        insReg = ADD_8_7_1;
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_valid", 32'(ex_valid), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        insReg = ADDI_10_9_0; in_valid = 1'b1;
        step();
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_x9", ex_rs1_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/data width.
REQ-002 SHALL have parameter PC_W, default 5, instruction-address width (matches jumpPC).
REQ-003 SHALL have parameter NREG, default 32, register-file depth (x0..x31).
REQ-004 SHALL have ports: clk  in  1  clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 insReg  in  XLEN  instruction from fetch stage register.
REQ-007 in_valid  in  1  insReg holds a real instruction.
REQ-008 wb_en / wb_addr / wb_data  in  1 / 5 / XLEN  writeback port.
REQ-009 stall  out  1  fetch holds PC and insReg this cycle.
REQ-010 jump / jumpPC  out  1 / PC_W  PC override request and target to fetch.
REQ-011 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered controls.
REQ-012 ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each; ex_rd  out  5; ex_funct3  out  3.

Function
REQ-013 Fields SHALL be: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
REQ-014 Opcodes SHALL be: 0110011 ALU-R, 0010011 ALU-I, 0000011 LOAD, 0100011 STORE, 1101111 JMP; any other = NOP (no writes, no memory).
REQ-015 ex_imm SHALL be sign-extended ins[31:20] for ALU-I/LOAD, sign-extended {ins[31:25],ins[11:7]} for STORE, 0 otherwise.
REQ-016 Register file SHALL be NREG x XLEN; reads combinational; write on clk rise when wb_en and wb_addr!=0; x0 always reads 0.
REQ-017 All ex_* outputs SHALL be registered: decode result appears 1 cycle after insReg presented (latency 1).
REQ-018 JMP with in_valid, not squashed, not stalled SHALL drive jump=1, jumpPC=ins[19:15][PC_W-1:0] combinationally in that cycle; JMP emits ex_valid=0 next cycle.
REQ-019 The instruction arriving in the cycle after an accepted JMP SHALL be squashed: ex_valid=0, no stall, no jump, regardless of its content.
REQ-020 Load-use: if the instruction in EX is a valid LOAD with ex_rd!=0 and ex_rd equals current rs1 (ALU-R/ALU-I/LOAD/STORE) or rs2 (ALU-R/STORE), stall=1 for exactly one cycle and a bubble (ex_valid=0, all ex controls 0) is issued.
REQ-021 During stall decode SHALL keep decoding the same insReg; next cycle it is issued normally.
REQ-022 Squash SHALL take priority over stall; stall SHALL take priority over jump (jump deferred to the cycle after the stall).
REQ-023 in_valid=0 SHALL produce a bubble and never assert stall or jump.
REQ-024 Bubbles SHALL set ex_reg_write, ex_mem_read, ex_mem_write to 0; data outputs SHALL be don't-care but 0 is preferred.

Reset
REQ-025 rst_n low SHALL asynchronously clear all ex_* outputs, all registers of the file, and the squash flag to 0.
REQ-026 stall and jump SHALL read 0 while rst_n is low; reset during a pending squash or stall cancels it.
REQ-027 First decode SHALL occur on the first clk rise with rst_n high and in_valid=1.

Configuration
REQ-028 Macro DECODE_BYPASS_EN defined: a read of register r in the same cycle wb_en=1, wb_addr=r (r!=0) SHALL return wb_data.
REQ-029 Macro DECODE_BYPASS_EN undefined: that read SHALL return the old stored value; new value visible the next cycle.

Verification
REQ-030 Reset, write x5=0x0000_00AA via wb, then ALU-I addi x6,x5,-1 -> next cycle ex_rs1_data=0xAA, ex_imm=0xFFFF_FFFF, ex_rd=6, ex_reg_write=1.
REQ-031 JMP target 0x13 with in_valid=1 -> same cycle jump=1, jumpPC=0x13; next instruction squashed (ex_valid=0); following one issued.
REQ-032 LOAD x7 then ALU-R add x8,x7,x1 -> stall=1 one cycle, bubble issued, add issued next cycle with ex_valid=1.
REQ-033 wb_en=1, wb_addr=0, wb_data=0xFFFF_FFFF, then read x0 -> ex_rs1_data=0.
REQ-034 Same-cycle wb x9=0x1234 and read of x9 -> 0x1234 with DECODE_BYPASS_EN, prior value without; rst_n asserted mid-stall -> stall=0, ex_valid=0 immediately.
